// File: rtl/nios_hps_system_nios_keys.sv
// rtl/nios_hps_system_nios_keys.sv - Avalon-MM input PIO with edge capture and maskable level irq
module nios_hps_system_nios_keys #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, prev;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [WIDTH-1:0] edge_sel, edge_det, cap_clr;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign armed        = (arm_cnt == 2'd3);
  assign unused_wdata = ^{1'b0, writedata};

  // Detection stays gated until the sync chain holds real pin samples.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_sel = sync2 & ~prev;
      1:       edge_sel = ~sync2 & prev;
      default: edge_sel = sync2 ^ prev;
    endcase
    edge_det = armed ? edge_sel : '0;
    cap_clr  = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      arm_cnt  <= 2'd0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
      if (!armed)
        arm_cnt <= arm_cnt + 2'd1;
      if (wr_en && address == 2'd2)
        irq_mask <= writedata[WIDTH-1:0];
      // A new edge outranks a same-cycle clear so no event is lost.
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = sync2;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_hps_system_nios_keys.sv
// tb/tb_nios_hps_system_nios_keys.sv - directed bench for the keys PIO in two configurations
module tb_nios_hps_system_nios_keys;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs0, cs1;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in0;
  logic [7:0]  in1;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_hps_system_nios_keys #(.WIDTH(4), .EDGE_TYPE(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0)
  );

  nios_hps_system_nios_keys #(.WIDTH(8), .EDGE_TYPE(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    address   = a;
    writedata = v;
    write_n   = 1'b0;
    cs0       = (d == 0);
    cs1       = (d == 1);
    tick();
    write_n   = 1'b1;
    cs0       = 1'b0;
    cs1       = 1'b0;
  endtask

  task automatic chk_rd(input int d, input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    check(tag, (d == 0) ? rd0 : rd1, exp);
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; cs0 = 1'b0; cs1 = 1'b0;
    write_n = 1'b1; writedata = '0; in0 = 4'hF; in1 = 8'h01;

    // 1: reset state, sync latency, arm gate
    tick(3);
    check("rst_irq0", {31'd0, irq0}, 32'd0);
    chk_rd(0, 2'd0, 32'h0, "rst_data");
    chk_rd(0, 2'd1, 32'h0, "rst_rsvd");
    chk_rd(0, 2'd2, 32'h0, "rst_mask");
    chk_rd(0, 2'd3, 32'h0, "rst_cap");
    reset_n = 1'b1;
    tick();
    chk_rd(0, 2'd0, 32'h0, "data_after1");
    tick();
    chk_rd(0, 2'd0, 32'hF, "data_after2");
    chk_rd(1, 2'd0, 32'h01, "d1_data_after2");
    tick(4);
    chk_rd(0, 2'd3, 32'h0, "arm_cap0");
    chk_rd(1, 2'd3, 32'h0, "arm_cap1");

    // 2: falling edge with mask on
    wr(0, 2'd2, 32'h5);
    chk_rd(0, 2'd2, 32'h5, "mask_rd");
    in0 = 4'hE;
    tick();
    chk_rd(0, 2'd0, 32'hF, "fe_data_k");
    tick();
    chk_rd(0, 2'd0, 32'hE, "fe_data_k1");
    chk_rd(0, 2'd3, 32'h0, "fe_cap_k1");
    check("fe_irq_k1", {31'd0, irq0}, 32'd0);
    tick();
    chk_rd(0, 2'd3, 32'h1, "fe_cap_k2");
    check("fe_irq_k2", {31'd0, irq0}, 32'd1);

    // 3: clear with 0 then 1
    wr(0, 2'd3, 32'h0);
    chk_rd(0, 2'd3, 32'h1, "clr0_cap");
    check("clr0_irq", {31'd0, irq0}, 32'd1);
    wr(0, 2'd3, 32'h1);
    chk_rd(0, 2'd3, 32'h0, "clr1_cap");
    check("clr1_irq", {31'd0, irq0}, 32'd0);

    // 4: set and clear on the same edge
    in0 = 4'hF;
    tick(4);
    chk_rd(0, 2'd3, 32'h0, "rise_ignored");
    in0 = 4'hE;
    tick(2);
    wr(0, 2'd3, 32'h1);
    chk_rd(0, 2'd3, 32'h1, "setclr_cap");
    check("setclr_irq", {31'd0, irq0}, 32'd1);
    wr(0, 2'd3, 32'h1);
    chk_rd(0, 2'd3, 32'h0, "setclr_after");

    // 5: masked edge on bit3, then unmask
    wr(0, 2'd2, 32'h0);
    in0 = 4'h6;
    tick(3);
    chk_rd(0, 2'd0, 32'h6, "m_data");
    chk_rd(0, 2'd3, 32'h8, "m_cap");
    check("m_irq_off", {31'd0, irq0}, 32'd0);
    wr(0, 2'd2, 32'h8);
    check("m_irq_on", {31'd0, irq0}, 32'd1);

    // 6: any-edge, 8 bits, ignored writes
    wr(1, 2'd0, 32'hFFFF_FFFF);
    wr(1, 2'd1, 32'hFFFF_FFFF);
    chk_rd(1, 2'd0, 32'h01, "w_data_ign");
    chk_rd(1, 2'd1, 32'h0, "w_rsvd_ign");
    wr(1, 2'd2, 32'hFFFF_FFFF);
    chk_rd(1, 2'd2, 32'hFF, "w_mask_trunc");
    in1 = 8'h81;
    tick(3);
    chk_rd(1, 2'd0, 32'h81, "any_data_hi");
    chk_rd(1, 2'd3, 32'h80, "any_rise_cap");
    check("any_irq", {31'd0, irq1}, 32'd1);
    wr(1, 2'd3, 32'h80);
    chk_rd(1, 2'd3, 32'h0, "any_clr");
    check("any_irq_clr", {31'd0, irq1}, 32'd0);
    tick(6);
    in1 = 8'h01;
    tick(3);
    chk_rd(1, 2'd0, 32'h01, "any_data_lo");
    chk_rd(1, 2'd3, 32'h80, "any_fall_cap");

    // reset while irq high and during a write
    check("pre_rst_irq0", {31'd0, irq0}, 32'd1);
    reset_n = 1'b0;
    wr(0, 2'd2, 32'hF);
    check("rst2_irq0", {31'd0, irq0}, 32'd0);
    check("rst2_irq1", {31'd0, irq1}, 32'd0);
    chk_rd(0, 2'd2, 32'h0, "rst2_mask");
    chk_rd(0, 2'd3, 32'h0, "rst2_cap");
    chk_rd(0, 2'd0, 32'h0, "rst2_data");
    chk_rd(1, 2'd3, 32'h0, "rst2_cap1");
    reset_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
